sprite_reg_arbiter: RTL and testbench

Shares the single access port of the sprite register file (43 x 16-bit game-state registers plus read-only status at addresses 48-51) between two requesters. The requesters are the CPU and the video sprite-fetch engine. On each vblank the block runs a burst that reads a contiguous window of sprite registers for the renderer, and it interleaves CPU accesses round-robin while the burst is active. It sits directly between the CPU bus and the register file's reg_addr/in/out/we port.

---
 rtl/sprite_reg_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sprite_reg_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_reg_arbiter.sv
// sprite_reg_arbiter
// Shares the single access port of the sprite register file between the CPU
// and the video sprite-fetch engine. A vid_start pulse launches a burst that
// reads BURST_LEN consecutive registers from BURST_BASE; CPU accesses are
// interleaved round-robin while the burst runs.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request, held until cpu_gnt
//   cpu_gnt                    combinational grant, access happens this cycle
//   cpu_rvalid/cpu_rdata       registered read response, one cycle after grant
//   vid_start                  vblank pulse starting a burst
//   vid_busy                   high while a burst is outstanding
//   vid_rvalid/idx/rdata       registered burst word and its offset
//   vid_done                   pulse with the last burst word
//   vid_overrun                sticky, vid_start seen while busy
//   reg_addr/wdata/we/rdata    register file access port
module sprite_reg_arbiter #(
  parameter int unsigned BURST_BASE = 0,
  parameter int unsigned BURST_LEN  = 32,
  parameter int unsigned NUM_REGS   = 43
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [5:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        vid_start,
  output logic        vid_busy,
  output logic        vid_rvalid,
  output logic [5:0]  vid_idx,
  output logic [15:0] vid_rdata,
  output logic        vid_done,
  output logic        vid_overrun,
  output logic [5:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_we,
  input  logic [15:0] reg_rdata
);

  localparam logic [5:0] BASE      = 6'(BURST_BASE);
  localparam logic [5:0] LAST      = 6'(BURST_LEN - 1);
  localparam logic [6:0] REG_LIMIT = 7'(NUM_REGS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DRAIN
  } state_t;

  typedef enum logic {
    WIN_CPU,
    WIN_VID
  } winner_t;

  state_t     state;
  winner_t    last_winner;
  logic [5:0] cnt;
  logic       vid_gnt;
  logic       addr_ok;

  // One access per cycle; CPU owns the port outside BURST, and during BURST
  // contention goes to whichever side did not win last.
  always_comb begin
    cpu_gnt = 1'b0;
    vid_gnt = 1'b0;
    if (state == S_BURST) begin
      if (!cpu_req || last_winner == WIN_CPU) begin
        vid_gnt = 1'b1;
      end else begin
        cpu_gnt = 1'b1;
      end
    end else begin
      cpu_gnt = cpu_req;
    end
  end

  // Writes above the writable range are acknowledged but never reach the file.
  assign addr_ok = {1'b0, cpu_addr} < REG_LIMIT;

  always_comb begin
    reg_addr  = '0;
    reg_wdata = '0;
    reg_we    = 1'b0;
    if (cpu_gnt) begin
      reg_addr  = cpu_addr;
      reg_wdata = cpu_wdata;
      reg_we    = cpu_we & addr_ok;
    end else if (vid_gnt) begin
      reg_addr = BASE + cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      last_winner <= WIN_VID;
      cnt         <= '0;
      cpu_rvalid  <= 1'b0;
      cpu_rdata   <= '0;
      vid_busy    <= 1'b0;
      vid_rvalid  <= 1'b0;
      vid_idx     <= '0;
      vid_rdata   <= '0;
      vid_done    <= 1'b0;
      vid_overrun <= 1'b0;
    end else begin
      if (cpu_gnt) begin
        last_winner <= WIN_CPU;
      end else if (vid_gnt) begin
        last_winner <= WIN_VID;
      end

      cpu_rvalid <= cpu_gnt & ~cpu_we;
      if (cpu_gnt && !cpu_we) begin
        cpu_rdata <= reg_rdata;
      end

      vid_rvalid <= vid_gnt;
      vid_done   <= vid_gnt && (cnt == LAST);
      if (vid_gnt) begin
        vid_idx   <= cnt;
        vid_rdata <= reg_rdata;
        cnt       <= cnt + 6'd1;
      end

      if (vid_start && state != S_IDLE) begin
        vid_overrun <= 1'b1;
      end

      // vid_busy tracks the next state so it is high exactly in BURST/DRAIN.
      case (state)
        S_IDLE: begin
          if (vid_start) begin
            state    <= S_BURST;
            cnt      <= '0;
            vid_busy <= 1'b1;
          end
        end
        S_BURST: begin
          if (vid_gnt && cnt == LAST) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          state    <= S_IDLE;
          vid_busy <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          vid_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_reg_arbiter.sv
// Directed bench for sprite_reg_arbiter with a small register-file model:
// addresses 0..63 hold 0x0100+addr after init, 48..51 read as 0xC000|addr.
module tb_sprite_reg_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [5:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic        vid_start;
  logic        vid_busy;
  logic        vid_rvalid;
  logic [5:0]  vid_idx;
  logic [15:0] vid_rdata;
  logic        vid_done;
  logic        vid_overrun;
  logic [5:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic [15:0] reg_rdata;

  logic        mem_init;
  logic [15:0] mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_reg_arbiter #(
    .BURST_BASE(0),
    .BURST_LEN (32),
    .NUM_REGS  (43)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .vid_start  (vid_start),
    .vid_busy   (vid_busy),
    .vid_rvalid (vid_rvalid),
    .vid_idx    (vid_idx),
    .vid_rdata  (vid_rdata),
    .vid_done   (vid_done),
    .vid_overrun(vid_overrun),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_we     (reg_we),
    .reg_rdata  (reg_rdata)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h0100 + 16'(i);
    end else if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
    end
  end

  always_comb begin
    if (reg_addr >= 6'd48 && reg_addr <= 6'd51) reg_rdata = 16'hC000 | {10'd0, reg_addr};
    else reg_rdata = mem[reg_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Register 5 is rewritten with 0x1234 before any burst.
  function automatic logic [15:0] exp_word(input int idx);
    return (idx == 5) ? 16'h1234 : 16'h0100 + 16'(idx);
  endfunction

  int busy_cnt, pulses, done_cnt, j, rv_cnt;
  logic prev_busy, found;

  initial begin
    reset = 1'b0; mem_init = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; vid_start = 1'b0;
    tick(); tick();
    mem_init = 1'b0;
    #1;
    check("reset_flags", {21'd0, cpu_rvalid, vid_busy, vid_rvalid, vid_done, vid_overrun, vid_idx}, 32'd0);
    check("reset_data", {cpu_rdata, vid_rdata}, 32'd0);
    reset = 1'b1;

    // CPU write then read in IDLE
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd5; cpu_wdata = 16'h1234;
    #1;
    check("cpu_wr_port", {cpu_gnt, reg_we, reg_addr, reg_wdata}, {8'd0, 1'b1, 1'b1, 6'd5, 16'h1234});
    tick();
    cpu_we = 1'b0;
    #1;
    check("cpu_rd_port", {cpu_gnt, reg_we, cpu_rvalid, reg_addr}, {23'd0, 1'b1, 1'b0, 1'b0, 6'd5});
    tick();
    cpu_req = 1'b0;
    #1;
    check("cpu_rd_resp", {cpu_rvalid, cpu_rdata}, {15'd0, 1'b1, 16'h1234});
    tick();
    #1;
    check("cpu_rd_hold", {cpu_rvalid, cpu_rdata}, {15'd0, 1'b0, 16'h1234});

    // Burst with no CPU traffic
    tick();
    vid_start = 1'b1;
    #1;
    check("burst_idle_busy", {31'd0, vid_busy}, 32'd0);
    tick();
    vid_start = 1'b0;
    #1;
    check("burst_first_port", {cpu_gnt, reg_we, reg_addr}, 32'd0);
    busy_cnt = 0; pulses = 0; done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (vid_busy) busy_cnt++;
      if (vid_rvalid) begin
        check("burst_idx", {26'd0, vid_idx}, 32'(pulses));
        check("burst_data", {16'd0, vid_rdata}, {16'd0, exp_word(pulses)});
        pulses++;
      end
      if (vid_done) begin
        check("burst_done_idx", {26'd0, vid_idx}, 32'd31);
        done_cnt++;
      end
      tick();
      #1;
    end
    check("burst_pulses", 32'(pulses), 32'd32);
    check("burst_busy_cycles", 32'(busy_cnt), 32'd33);
    check("burst_done_cnt", 32'(done_cnt), 32'd1);

    // Contention: CPU reads of status addr 48 held across the whole burst
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd48;
    tick();
    vid_start = 1'b1;
    #1;
    check("cont_idle_gnt", {31'd0, cpu_gnt}, 32'd1);
    tick();
    vid_start = 1'b0;
    #1;
    j = 0; rv_cnt = 0; pulses = 0; done_cnt = 0; prev_busy = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (prev_busy && cpu_rvalid) begin
        check("cont_cpu_data", {16'd0, cpu_rdata}, 32'h0000C030);
        rv_cnt++;
      end
      if (vid_busy) begin
        check("cont_alternate", {31'd0, cpu_gnt}, 32'(j % 2));
        j++;
      end
      if (vid_rvalid) pulses++;
      if (vid_done) begin
        check("cont_last_data", {16'd0, vid_rdata}, 32'h0000011F);
        done_cnt++;
      end
      prev_busy = vid_busy;
      tick();
      #1;
    end
    check("cont_busy_cycles", 32'(j), 32'd64);
    check("cont_cpu_rvalids", 32'(rv_cnt), 32'd32);
    check("cont_vid_pulses", 32'(pulses), 32'd32);
    check("cont_done_cnt", 32'(done_cnt), 32'd1);
    cpu_req = 1'b0;

    // Write protection
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd49; cpu_wdata = 16'hFFFF;
    #1;
    check("wp_addr49", {30'd0, cpu_gnt, reg_we}, 32'd2);
    tick();
    cpu_addr = 6'd43;
    #1;
    check("wp_addr43", {30'd0, cpu_gnt, reg_we}, 32'd2);
    tick();
    cpu_we = 1'b0; cpu_addr = 6'd42;
    #1;
    check("wp_rd42_gnt", {31'd0, cpu_gnt}, 32'd1);
    tick();
    cpu_req = 1'b0;
    #1;
    check("wp_rd42_data", {cpu_rvalid, cpu_rdata}, {15'd0, 1'b1, 16'h012A});

    // Overrun: second vid_start mid-burst
    tick();
    vid_start = 1'b1;
    tick();
    pulses = 0; done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      vid_start = (k == 9);
      #1;
      if (k == 1) check("ovr_before", {31'd0, vid_overrun}, 32'd0);
      if (vid_rvalid) begin
        check("ovr_idx", {26'd0, vid_idx}, 32'(pulses));
        pulses++;
      end
      if (vid_done) done_cnt++;
      tick();
    end
    #1;
    check("ovr_pulses", 32'(pulses), 32'd32);
    check("ovr_done_cnt", 32'(done_cnt), 32'd1);
    check("ovr_sticky", {30'd0, vid_overrun, vid_busy}, 32'd2);

    // Reset mid-burst
    tick();
    vid_start = 1'b1;
    tick();
    vid_start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (vid_rvalid && vid_idx == 6'd7) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("rst_word7_seen", {31'd0, found}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_flags", {21'd0, cpu_rvalid, vid_busy, vid_rvalid, vid_done, vid_overrun, vid_idx}, 32'd0);
    check("rst_data", {cpu_rdata, vid_rdata}, 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    vid_start = 1'b1;
    #1;
    check("rst_idle_busy", {31'd0, vid_busy}, 32'd0);
    tick();
    vid_start = 1'b0;
    pulses = 0; done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (vid_rvalid) begin
        if (pulses == 0) check("rst_restart_idx0", {26'd0, vid_idx}, 32'd0);
        pulses++;
      end
      if (vid_done) done_cnt++;
      tick();
    end
    check("rst_restart_pulses", 32'(pulses), 32'd32);
    check("rst_restart_done", 32'(done_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
